// File: rtl/if_id_stage.sv
// IF/ID pipeline register: holds the fetched instruction and its PC+2, handles stall, flush and HALT.
// Optional perf counters (stall_cnt, flush_cnt) are built when IF_ID_PERF_CNT_EN is defined.
//
// state  | meaning
// RUN    | normal operation, fetch advances unless stalled
// HALTED | a HALT has been captured; decode sees only bubbles, fetch is frozen
module if_id_stage #(
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_in,
    input  logic [15:0] PC_plus_two_in,
    input  logic        fetch_valid,
    input  logic        stall,
    input  logic        flush,
    output logic [15:0] instr_out,
    output logic [15:0] PC_plus_two_out,
    output logic        valid_out,
    output logic        nop_out,
    output logic        halted_out,
    output logic        fetch_en
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t state;

    assign halted_out = (state == HALTED);
    assign nop_out    = ~valid_out;
    assign fetch_en   = flush | (~stall & ~halted_out);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= RUN;
            instr_out       <= NOP_INSTR;
            PC_plus_two_out <= 16'h0000;
            valid_out       <= 1'b0;
        end else if (flush) begin
            // PC+2 is deliberately kept; the squashed slot never reaches execute.
            state     <= RUN;
            instr_out <= NOP_INSTR;
            valid_out <= 1'b0;
        end else if (stall) begin
            state           <= state;
            instr_out       <= instr_out;
            PC_plus_two_out <= PC_plus_two_out;
            valid_out       <= valid_out;
        end else begin
            PC_plus_two_out <= PC_plus_two_in;
            if (state == RUN && fetch_valid) begin
                instr_out <= instr_in;
                valid_out <= 1'b1;
                if (instr_in[15:11] == HALT_OPC) begin
                    state <= HALTED;
                end
            end else begin
                instr_out <= NOP_INSTR;
                valid_out <= 1'b0;
            end
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'h0000;
            flush_cnt <= 16'h0000;
        end else begin
            if (stall && !flush && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush && flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios followed by random traffic
// compared against a cycle-level behavioural model of the IF/ID slot.
module tb_if_id_stage;

    logic        clk;
    logic        rst;
    logic [15:0] instr_in;
    logic [15:0] PC_plus_two_in;
    logic        fetch_valid;
    logic        stall;
    logic        flush;
    logic [15:0] instr_out;
    logic [15:0] PC_plus_two_out;
    logic        valid_out;
    logic        nop_out;
    logic        halted_out;
    logic        fetch_en;
`ifdef IF_ID_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    if_id_stage dut (
        .clk            (clk),
        .rst            (rst),
        .instr_in       (instr_in),
        .PC_plus_two_in (PC_plus_two_in),
        .fetch_valid    (fetch_valid),
        .stall          (stall),
        .flush          (flush),
        .instr_out      (instr_out),
        .PC_plus_two_out(PC_plus_two_out),
        .valid_out      (valid_out),
        .nop_out        (nop_out),
        .halted_out     (halted_out),
        .fetch_en       (fetch_en)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the decode slot: what decode should see, and whether fetch is frozen.
    logic [15:0] m_instr;
    logic [15:0] m_pc;
    logic        m_valid;
    logic        m_halted;
    int          m_stalls;
    int          m_flushes;
    bit          m_known = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Apply one cycle of stimulus; called at a falling edge, returns at the next falling edge.
    task automatic drive(input bit r, input bit fv, input bit st, input bit fl,
                         input logic [15:0] ins, input logic [15:0] pc);
        rst            = r;
        fetch_valid    = fv;
        stall          = st;
        flush          = fl;
        instr_in       = ins;
        PC_plus_two_in = pc;
        #1;
        if (m_known) begin
            check("fetch_en", fetch_en, fl | (!st && !m_halted));
            check("nop_out", nop_out, !m_valid);
        end
        @(posedge clk);
        if (r) begin
            m_instr = 16'h0800; m_pc = 16'h0000; m_valid = 0; m_halted = 0;
            m_stalls = 0; m_flushes = 0; m_known = 1;
        end else if (fl) begin
            m_instr = 16'h0800; m_valid = 0; m_halted = 0;
            m_flushes = sat_inc(m_flushes);
        end else if (st) begin
            m_stalls = sat_inc(m_stalls);
        end else begin
            m_pc = pc;
            if (!m_halted && fv) begin
                m_instr = ins; m_valid = 1;
                if (ins[15:11] == 5'b00000) m_halted = 1;
            end else begin
                m_instr = 16'h0800; m_valid = 0;
            end
        end
        #1;
        if (m_known) begin
            check("instr_out", instr_out, m_instr);
            check("pc_out", PC_plus_two_out, m_pc);
            check("valid_out", valid_out, m_valid);
            check("halted_out", halted_out, m_halted);
`ifdef IF_ID_PERF_CNT_EN
            check("stall_cnt", stall_cnt, m_stalls);
            check("flush_cnt", flush_cnt, m_flushes);
`endif
        end
        @(negedge clk);
    endtask

    function automatic logic [15:0] rnd16();
        return 16'($urandom);
    endfunction

    initial begin
        rst = 1; fetch_valid = 0; stall = 0; flush = 0; instr_in = 0; PC_plus_two_in = 0;
        @(negedge clk);

        // reset held two cycles with random inputs
        repeat (2) drive(1, 1'($urandom), 1'($urandom), 1'($urandom), rnd16(), rnd16());
        check("rst_instr", instr_out, 16'h0800);
        check("rst_pc", PC_plus_two_out, 16'h0000);
        check("rst_valid", valid_out, 1'b0);
        check("rst_nop", nop_out, 1'b1);
        check("rst_halted", halted_out, 1'b0);

        // load then stall three cycles
        drive(0, 1, 0, 0, 16'hC123, 16'h0012);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'($urandom), 1, 0, rnd16() | 16'h8000, rnd16());
            check("stall_instr", instr_out, 16'hC123);
            check("stall_pc", PC_plus_two_out, 16'h0012);
            stall = 1; #1;
            check("stall_fetch_en", fetch_en, 1'b0);
            #1;
        end
`ifdef IF_ID_PERF_CNT_EN
        check("stall_cnt3", stall_cnt, 16'd3);
`endif

        // stall and flush together: flush wins
        drive(0, 1, 1, 1, 16'h4444, 16'h0014);
        check("sf_instr", instr_out, 16'h0800);
        check("sf_valid", valid_out, 1'b0);
        check("sf_pc_hold", PC_plus_two_out, 16'h0012);
`ifdef IF_ID_PERF_CNT_EN
        check("sf_flush_cnt", flush_cnt, 16'd1);
        check("sf_stall_cnt", stall_cnt, 16'd3);
`endif

        // HALT capture
        drive(0, 1, 0, 0, 16'h0000, 16'h0030);
        check("halt_valid", valid_out, 1'b1);
        check("halt_state", halted_out, 1'b1);
        check("halt_fetch_en", fetch_en, 1'b0);
        drive(0, 1, 0, 0, 16'h4000, 16'h0032);
        check("halted_instr", instr_out, 16'h0800);
        check("halted_valid", valid_out, 1'b0);

        // HALT cancelled by flush
        drive(0, 1, 0, 1, 16'h4000, 16'h0034);
        check("unhalt_state", halted_out, 1'b0);
        drive(0, 1, 0, 0, 16'h4000, 16'h0036);
        check("unhalt_instr", instr_out, 16'h4000);
        check("unhalt_valid", valid_out, 1'b1);

        // bubble when fetch is not valid
        drive(0, 0, 0, 0, 16'h5555, 16'h0020);
        check("bub_instr", instr_out, 16'h0800);
        check("bub_valid", valid_out, 1'b0);
        check("bub_pc", PC_plus_two_out, 16'h0020);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] ins;
            ins = rnd16();
            if ($urandom_range(0, 7) == 0) ins[15:11] = 5'b00000;
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, ins, rnd16());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
